flappy_game_ctrl: RTL

Game-level controller and score keeper on the consuming side of the pipe renderer's status interface. It gates the pipe renderer via pipe_enable and pipe_clear, counts pipe_passed pulses into a 3-digit BCD score, and ends the run on pipe_collision or ground_hit. It also keeps a BCD high score across runs and runs the IDLE/PLAY/DYING/OVER game state machine from a raw flap button.

---
 rtl/flappy_game_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: game state machine, BCD score and high score keeper
// sitting on the status side of the pipe renderer.
module flappy_game_ctrl #(
    parameter int DEATH_CYCLES = 50_000_000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flap_btn,
    input  logic        pipe_passed,
    input  logic        pipe_collision,
    input  logic        ground_hit,
    output logic        pipe_enable,
    output logic        pipe_clear,
    output logic        flap_pulse,
    output logic [1:0]  game_state,
    output logic [11:0] score_bcd,
    output logic [11:0] high_bcd,
    output logic        new_high
);

    localparam int CW = (DEATH_CYCLES > 1) ? $clog2(DEATH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEATH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   synced_d;
    logic                   flap_edge;
    logic [CW-1:0]          death_cnt;
    logic                   hit;

    // BCD +1 with per-digit carry, saturating at 999
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] d0, d1, d2;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        if (v != 12'h999) begin
            if (d0 == 4'd9) begin
                d0 = 4'd0;
                if (d1 == 4'd9) begin
                    d1 = 4'd0;
                    d2 = d2 + 4'd1;
                end else begin
                    d1 = d1 + 4'd1;
                end
            end else begin
                d0 = d0 + 4'd1;
            end
        end
        return {d2, d1, d0};
    endfunction

    // The renderer is being reset while pipe_clear is high, so its
    // collision status is not trusted during that cycle.
    assign hit        = (pipe_collision | ground_hit) & ~pipe_clear;
    assign game_state = state;

    // Synchronize the raw button and register its rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync      <= '0;
            synced_d  <= 1'b0;
            flap_edge <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], flap_btn};
            synced_d  <= sync[SYNC_STAGES-1];
            flap_edge <= sync[SYNC_STAGES-1] & ~synced_d;
        end
    end

    // Game FSM with registered outputs, score and high score
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pipe_enable <= 1'b0;
            pipe_clear  <= 1'b0;
            flap_pulse  <= 1'b0;
            score_bcd   <= 12'h000;
            high_bcd    <= 12'h000;
            new_high    <= 1'b0;
            death_cnt   <= '0;
        end else begin
            pipe_clear <= 1'b0;
            flap_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (flap_edge) begin
                        state       <= PLAY;
                        pipe_clear  <= 1'b1;
                        pipe_enable <= 1'b1;
                        flap_pulse  <= 1'b1;
                        score_bcd   <= 12'h000;
                        new_high    <= 1'b0;
                    end
                end
                PLAY: begin
                    flap_pulse <= flap_edge;
                    if (hit) begin
                        state       <= DYING;
                        pipe_enable <= 1'b0;
                        death_cnt   <= '0;
                    end else if (pipe_passed) begin
                        score_bcd <= bcd_inc(score_bcd);
                    end
                end
                DYING: begin
                    if (death_cnt == LAST) begin
                        state <= OVER;
                        // Valid BCD packed MSD-first orders like the digit compare
                        if (score_bcd > high_bcd) begin
                            high_bcd <= score_bcd;
                            new_high <= 1'b1;
                        end
                    end else begin
                        death_cnt <= death_cnt + CW'(1);
                    end
                end
                OVER: begin
                    if (flap_edge) begin
                        state      <= IDLE;
                        pipe_clear <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
